// File: rtl/eth_mac_regs_pkg.sv
// Shared definitions for the Ethernet MAC register window: offsets, response
// codes, decode helper and byte-lane merge helper.
package eth_mac_regs_pkg;

    localparam int ETH_ADDR_W = 48;

    // Register offsets relative to the window base address
    localparam logic [31:0] UWA0_OFFSET   = 32'h0000_0700;
    localparam logic [31:0] UWA1_OFFSET   = 32'h0000_0704;
    localparam logic [31:0] CTRL_OFFSET   = 32'h0000_0708;
    localparam logic [31:0] STATUS_OFFSET = 32'h0000_070C;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        SEL_UWA0,
        SEL_UWA1,
        SEL_CTRL,
        SEL_STATUS,
        SEL_NONE
    } reg_sel_e;

    // Full 32-bit decode; the byte offset within a word is ignored.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                             input logic [31:0] base);
        logic [31:0] word;
        word = addr & ~32'h0000_0003;
        if (word == base + UWA0_OFFSET)
            return SEL_UWA0;
        else if (word == base + UWA1_OFFSET)
            return SEL_UWA1;
        else if (word == base + CTRL_OFFSET)
            return SEL_CTRL;
        else if (word == base + STATUS_OFFSET)
            return SEL_STATUS;
        else
            return SEL_NONE;
    endfunction

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i])
                res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/eth_mac_regs.sv
// AXI-Lite register window for the Ethernet MAC: staged unicast address
// (low word staged, committed atomically on the high-word write), enable
// control and a pending-stage status flag.
module eth_mac_regs
    import eth_mac_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h40C0_0000
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [31:0]           S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,

    input  logic [31:0]           S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,

    output logic [ETH_ADDR_W-1:0] unicast_addr,
    output logic                  unicast_valid,
    output logic                  mac_enable
);

    // Held write-address / write-data channel state
    logic        ready_en;
    logic        aw_held;
    logic [31:0] aw_addr_q;
    logic        w_held;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    // Response channel state
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;

    // Architectural registers
    logic [31:0]           staging_q;
    logic                  stage_pending_q;
    logic [ETH_ADDR_W-1:0] unicast_addr_q;
    logic                  unicast_valid_q;
    logic                  mac_enable_q;

    // Write-path combinational signals
    logic        aw_ready;
    logic        w_ready;
    logic        aw_hs;
    logic        w_hs;
    logic        wr_fire;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    reg_sel_e    wr_sel;
    logic        wr_ok;
    logic [31:0] staging_merged;
    logic [15:0] uwa1_merged;

    // Read-path combinational signals
    logic        ar_ready;
    logic        ar_hs;
    reg_sel_e    rd_sel;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    assign aw_ready = ready_en & ~aw_held & ~bvalid_q;
    assign w_ready  = ready_en & ~w_held & ~bvalid_q;
    assign ar_ready = ready_en & ~rvalid_q;

    assign aw_hs = S_AXI_AWVALID & aw_ready;
    assign w_hs  = S_AXI_WVALID & w_ready;
    assign ar_hs = S_AXI_ARVALID & ar_ready;

    // Write fires when both halves are present, whether held or arriving now
    assign wr_fire = (aw_held | aw_hs) & (w_held | w_hs);

    // Pick held or live write channel values and compute merged register images
    always_comb begin
        wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
        wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
        wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;
        wr_sel  = decode_addr(wr_addr, BASE_ADDR);
        wr_ok   = (wr_sel == SEL_UWA0) || (wr_sel == SEL_UWA1) || (wr_sel == SEL_CTRL);
        staging_merged = merge_strb(staging_q, wr_data, wr_strb);
        uwa1_merged[7:0]  = wr_strb[0] ? wr_data[7:0]  : unicast_addr_q[39:32];
        uwa1_merged[15:8] = wr_strb[1] ? wr_data[15:8] : unicast_addr_q[47:40];
    end

    // Decode the read address and select the committed register contents
    always_comb begin
        rd_sel  = decode_addr(S_AXI_ARADDR, BASE_ADDR);
        rd_data = 32'h0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            SEL_UWA0:   rd_data = unicast_addr_q[31:0];
            SEL_UWA1:   rd_data = {16'h0, unicast_addr_q[47:32]};
            SEL_CTRL:   rd_data = {31'h0, mac_enable_q};
            SEL_STATUS: rd_data = {31'h0, stage_pending_q};
            default:    rd_resp = RESP_SLVERR;
        endcase
    end

    // Write path: channel capture, register update and write response
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en        <= 1'b0;
            aw_held         <= 1'b0;
            aw_addr_q       <= 32'h0;
            w_held          <= 1'b0;
            w_data_q        <= 32'h0;
            w_strb_q        <= 4'h0;
            bvalid_q        <= 1'b0;
            bresp_q         <= RESP_OKAY;
            staging_q       <= 32'h0;
            stage_pending_q <= 1'b0;
            unicast_addr_q  <= '0;
            unicast_valid_q <= 1'b0;
            mac_enable_q    <= 1'b0;
        end else begin
            ready_en        <= 1'b1;
            unicast_valid_q <= 1'b0;

            if (bvalid_q && S_AXI_BREADY)
                bvalid_q <= 1'b0;

            if (wr_fire) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                case (wr_sel)
                    SEL_UWA0: begin
                        staging_q       <= staging_merged;
                        stage_pending_q <= 1'b1;
                    end
                    SEL_UWA1: begin
                        unicast_addr_q  <= {uwa1_merged, staging_q};
                        stage_pending_q <= 1'b0;
                        unicast_valid_q <= 1'b1;
                    end
                    SEL_CTRL: begin
                        if (wr_strb[0])
                            mac_enable_q <= wr_data[0];
                    end
                    default: begin
                    end
                endcase
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end
        end
    end

    // Read path: capture data on address handshake and hold until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (rvalid_q && S_AXI_RREADY)
                rvalid_q <= 1'b0;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign unicast_addr  = unicast_addr_q;
    assign unicast_valid = unicast_valid_q;
    assign mac_enable    = mac_enable_q;

endmodule

// File: tb/tb_eth_mac_regs.sv
// Self-checking bench for eth_mac_regs: vector table plus hand-written
// sequences for split AW/W, back-pressure, read/write collision and reset.
module tb_eth_mac_regs;
    import eth_mac_regs_pkg::*;

    localparam logic [31:0] BASE = 32'h40C0_0000;

    logic        aclk;
    logic        aresetn;
    logic [31:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [47:0] unicast_addr;
    logic        unicast_valid;
    logic        mac_enable;

    eth_mac_regs #(.BASE_ADDR(BASE)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .unicast_addr  (unicast_addr),
        .unicast_valid (unicast_valid),
        .mac_enable    (mac_enable)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } rd_exp_t;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [1:0] exp_b_q[$];
    rd_exp_t    exp_r_q[$];
    vec_t       vecs[$];
    logic       uv_at_b;
    logic       uv_after_b;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input string name);
        int         cnt;
        bit         aw_done, w_done, aw_fire, w_fire;
        logic [1:0] exp;
        exp_b_q.push_back(exp_resp);
        S_AXI_BREADY  = 1'b1;
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_WVALID  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cnt     = 0;
        while (!(aw_done && w_done) && cnt < 20) begin
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_fire) begin
                aw_done = 1'b1;
                S_AXI_AWVALID = 1'b0;
            end
            if (w_fire) begin
                w_done = 1'b1;
                S_AXI_WVALID = 1'b0;
            end
            cnt++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        checkOutput({name, " aw/w handshake"}, 64'({aw_done, w_done}), 64'd3);
        cnt = 0;
        while (!S_AXI_BVALID && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput({name, " bvalid"}, 64'(S_AXI_BVALID), 64'd1);
        exp = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 2'bxx;
        checkOutput({name, " bresp"}, 64'(S_AXI_BRESP), 64'(exp));
        uv_at_b = unicast_valid;
        tick();
        uv_after_b = unicast_valid;
    endtask

    task automatic doRead(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string name);
        int      cnt;
        bit      ar_done, ar_fire;
        rd_exp_t e;
        e.rdata = exp_data;
        e.rresp = exp_resp;
        exp_r_q.push_back(e);
        S_AXI_RREADY  = 1'b1;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        ar_done = 1'b0;
        cnt     = 0;
        while (!ar_done && cnt < 20) begin
            ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
            tick();
            if (ar_fire) ar_done = 1'b1;
            cnt++;
        end
        S_AXI_ARVALID = 1'b0;
        checkOutput({name, " ar handshake"}, 64'(ar_done), 64'd1);
        cnt = 0;
        while (!S_AXI_RVALID && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput({name, " rvalid"}, 64'(S_AXI_RVALID), 64'd1);
        if (exp_r_q.size() > 0) e = exp_r_q.pop_front();
        checkOutput({name, " rdata"}, 64'(S_AXI_RDATA), 64'(e.rdata));
        checkOutput({name, " rresp"}, 64'(S_AXI_RRESP), 64'(e.rresp));
        tick();
    endtask

    task automatic addVec(input bit w, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp,
                          input logic [31:0] rdata);
        vec_t v;
        v.is_wr = w;
        v.addr  = addr;
        v.data  = data;
        v.strb  = strb;
        v.resp  = resp;
        v.rdata = rdata;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        if (v.is_wr)
            doWrite(v.addr, v.data, v.strb, v.resp, $sformatf("vec%0d wr", idx));
        else
            doRead(v.addr, v.rdata, v.resp, $sformatf("vec%0d rd", idx));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rd_exp_t    re;
        logic [1:0] be;

        aresetn       = 1'b0;
        S_AXI_AWADDR  = 32'h0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = 32'h0;
        S_AXI_WSTRB   = 4'h0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = 32'h0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        uv_at_b       = 1'b0;
        uv_after_b    = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst awready", 64'(S_AXI_AWREADY), 64'd0);
        checkOutput("rst wready", 64'(S_AXI_WREADY), 64'd0);
        checkOutput("rst arready", 64'(S_AXI_ARREADY), 64'd0);
        checkOutput("rst bvalid", 64'(S_AXI_BVALID), 64'd0);
        checkOutput("rst rvalid", 64'(S_AXI_RVALID), 64'd0);
        checkOutput("rst rdata", 64'(S_AXI_RDATA), 64'd0);
        checkOutput("rst unicast_addr", 64'(unicast_addr), 64'd0);
        checkOutput("rst unicast_valid", 64'(unicast_valid), 64'd0);
        checkOutput("rst mac_enable", 64'(mac_enable), 64'd0);
        aresetn = 1'b1;
        tick();
        checkOutput("post-rst awready", 64'(S_AXI_AWREADY), 64'd1);
        checkOutput("post-rst arready", 64'(S_AXI_ARREADY), 64'd1);

        // Basic staged commit of the unicast address
        doWrite(BASE + UWA0_OFFSET, 32'hDDCC_BBAA, 4'hF, RESP_OKAY, "uwa0 first");
        checkOutput("uwa0 does not commit", 64'(unicast_addr), 64'd0);
        checkOutput("uwa0 no valid pulse", 64'(uv_at_b), 64'd0);
        doWrite(BASE + UWA1_OFFSET, 32'h0000_FFEE, 4'hF, RESP_OKAY, "uwa1 first");
        checkOutput("commit valid pulse", 64'(uv_at_b), 64'd1);
        checkOutput("commit valid one cycle", 64'(uv_after_b), 64'd0);
        checkOutput("committed address", 64'(unicast_addr), 64'h0000_FFEE_DDCC_BBAA);

        // Vector table: state continues from the commit above
        addVec(1, BASE + UWA0_OFFSET,   32'h0102_0304, 4'hF, RESP_OKAY,   32'h0);
        addVec(0, BASE + STATUS_OFFSET, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0001);
        addVec(0, BASE + UWA0_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'hDDCC_BBAA);
        addVec(0, BASE + UWA1_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'h0000_FFEE);
        addVec(1, BASE + UWA1_OFFSET,   32'h0000_0A0B, 4'hF, RESP_OKAY,   32'h0);
        addVec(0, BASE + STATUS_OFFSET, 32'h0,         4'h0, RESP_OKAY,   32'h0);
        addVec(0, BASE + UWA0_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'h0102_0304);
        addVec(0, BASE + UWA1_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'h0000_0A0B);
        addVec(1, BASE + CTRL_OFFSET,   32'h0000_0001, 4'hF, RESP_OKAY,   32'h0);
        addVec(0, BASE + CTRL_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'h0000_0001);
        addVec(1, BASE + 32'h710,       32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 32'h0);
        addVec(1, BASE + STATUS_OFFSET, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 32'h0);
        addVec(0, BASE + 32'h800,       32'h0,         4'h0, RESP_SLVERR, 32'h0);
        addVec(0, BASE + STATUS_OFFSET, 32'h0,         4'h0, RESP_OKAY,   32'h0);
        addVec(0, BASE + CTRL_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'h0000_0001);
        addVec(1, 32'h50C0_0700,        32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 32'h0);
        addVec(0, BASE + 32'h702,       32'h0,         4'h0, RESP_OKAY,   32'h0102_0304);
        addVec(1, BASE + UWA1_OFFSET,   32'h0000_0011, 4'h1, RESP_OKAY,   32'h0);
        addVec(0, BASE + UWA1_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'h0000_0A11);
        addVec(1, BASE + UWA1_OFFSET,   32'hFFFF_0000, 4'hC, RESP_OKAY,   32'h0);
        addVec(0, BASE + UWA1_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'h0000_0A11);
        addVec(1, BASE + CTRL_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'h0);
        addVec(0, BASE + CTRL_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'h0000_0001);
        addVec(0, BASE + UWA0_OFFSET,   32'h0,         4'h0, RESP_OKAY,   32'h0102_0304);
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        // Partial byte-lane write into the staging register
        doWrite(BASE + UWA0_OFFSET, 32'h1122_3344, 4'hF, RESP_OKAY, "stage full");
        doWrite(BASE + UWA0_OFFSET, 32'h0000_5500, 4'h2, RESP_OKAY, "stage lane1");
        doWrite(BASE + UWA1_OFFSET, 32'h0000_0000, 4'h0, RESP_OKAY, "commit no lanes");
        checkOutput("lane merge commit", 64'(unicast_addr), 64'h0000_0A11_1122_5544);
        doRead(BASE + UWA0_OFFSET, 32'h1122_5544, RESP_OKAY, "lane merge read");

        // AW three cycles ahead of W, response held under back-pressure
        exp_b_q.push_back(RESP_OKAY);
        S_AXI_BREADY  = 1'b0;
        S_AXI_AWADDR  = BASE + CTRL_OFFSET;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        checkOutput("split awready after aw", 64'(S_AXI_AWREADY), 64'd0);
        tick();
        tick();
        checkOutput("split no b before w", 64'(S_AXI_BVALID), 64'd0);
        checkOutput("split wready before w", 64'(S_AXI_WREADY), 64'd1);
        S_AXI_WDATA  = 32'h0;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        checkOutput("split bvalid latency", 64'(S_AXI_BVALID), 64'd1);
        be = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 2'bxx;
        checkOutput("split bresp", 64'(S_AXI_BRESP), 64'(be));
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("split bvalid hold %0d", i), 64'(S_AXI_BVALID), 64'd1);
            checkOutput($sformatf("split bresp hold %0d", i), 64'(S_AXI_BRESP), 64'(be));
            checkOutput($sformatf("split awready hold %0d", i), 64'(S_AXI_AWREADY), 64'd0);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        checkOutput("split bvalid cleared", 64'(S_AXI_BVALID), 64'd0);
        checkOutput("split awready restored", 64'(S_AXI_AWREADY), 64'd1);
        checkOutput("split ctrl written", 64'(mac_enable), 64'd0);

        // Read and write of CTRL in the same cycle: read sees the old value
        re.rdata = 32'h0;
        re.rresp = RESP_OKAY;
        exp_r_q.push_back(re);
        exp_b_q.push_back(RESP_OKAY);
        S_AXI_ARADDR  = BASE + CTRL_OFFSET;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR  = BASE + CTRL_OFFSET;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'h0000_0001;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        re = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : '{32'hx, 2'bx};
        be = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 2'bxx;
        checkOutput("collide rvalid", 64'(S_AXI_RVALID), 64'd1);
        checkOutput("collide rdata old", 64'(S_AXI_RDATA), 64'(re.rdata));
        checkOutput("collide bvalid", 64'(S_AXI_BVALID), 64'd1);
        checkOutput("collide bresp", 64'(S_AXI_BRESP), 64'(be));
        checkOutput("collide write landed", 64'(mac_enable), 64'd1);
        tick();
        doRead(BASE + CTRL_OFFSET, 32'h0000_0001, RESP_OKAY, "collide readback");

        // Reset while a write response is pending
        exp_b_q.push_back(RESP_OKAY);
        S_AXI_BREADY  = 1'b0;
        S_AXI_AWADDR  = BASE + UWA0_OFFSET;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'hCAFE_F00D;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        checkOutput("rst-mid bvalid pending", 64'(S_AXI_BVALID), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        exp_b_q.delete();
        checkOutput("rst-mid bvalid", 64'(S_AXI_BVALID), 64'd0);
        checkOutput("rst-mid unicast_addr", 64'(unicast_addr), 64'd0);
        checkOutput("rst-mid mac_enable", 64'(mac_enable), 64'd0);
        checkOutput("rst-mid awready", 64'(S_AXI_AWREADY), 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        S_AXI_BREADY = 1'b1;
        tick();
        checkOutput("rst-mid ready restored", 64'(S_AXI_AWREADY), 64'd1);
        doWrite(BASE + CTRL_OFFSET, 32'h0000_0001, 4'hF, RESP_OKAY, "post-rst ctrl");
        doRead(BASE + CTRL_OFFSET, 32'h0000_0001, RESP_OKAY, "post-rst ctrl rd");
        doRead(BASE + STATUS_OFFSET, 32'h0, RESP_OKAY, "post-rst status rd");
        doRead(BASE + UWA0_OFFSET, 32'h0, RESP_OKAY, "post-rst uwa0 rd");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/eth_mac_regs.md
ETH_MAC_REGS -- requirements
Module: eth_mac_regs

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h40C0_0000, meaning the byte address of the register window.
REQ-002 SHALL have port aclk  input  1  the single clock; all logic on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have AXI-Lite write ports: S_AXI_AWADDR in 32, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1, S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-005 SHALL have AXI-Lite read ports: S_AXI_ARADDR in 32, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-006 SHALL have unicast_addr  output  48  committed MAC unicast address; unicast_valid  output  1  one-cycle commit pulse; mac_enable  output  1  CTRL bit 0.

Function
REQ-007 Register map (offset from BASE_ADDR): UWA0 0x700 RW bits[31:0] = address[31:0]; UWA1 0x704 RW bits[15:0] = address[47:32], bits[31:16] read 0; CTRL 0x708 RW bit0 = enable; STATUS 0x70C RO bit0 = stage_pending.
REQ-008 Decode SHALL compare the full 32-bit address; ADDR[1:0] ignored; any other address is unmapped.
REQ-009 Write SHALL honour WSTRB per byte lane; lanes with strobe 0 unchanged.
REQ-010 UWA0 write updates a staging register and sets stage_pending; unicast_addr unchanged.
REQ-011 UWA1 write commits {UWA1[15:0] as merged, staging[31:0]} to unicast_addr on the same edge, clears stage_pending, pulses unicast_valid high exactly one cycle after that edge.
REQ-012 AW and W accepted independently; AWREADY = no AW held and BVALID low; WREADY = no W held and BVALID low.
REQ-013 Write executes on the edge where both AW and W are held or arrive (same-cycle arrival allowed); BVALID asserts the following cycle (latency 1 from last of AW/W handshake).
REQ-014 BVALID SHALL remain high, BRESP stable, until BREADY; no new AW/W accepted while BVALID high.
REQ-015 BRESP SHALL be 2'b00 OKAY for mapped RW; 2'b10 SLVERR for unmapped or STATUS write, with no state change.
REQ-016 ARREADY = RVALID low; on AR handshake RDATA/RRESP registered, RVALID high next cycle, held stable until RREADY.
REQ-017 Reads SHALL return committed unicast_addr (not staging) for UWA0/UWA1; unmapped read returns RDATA 0, RRESP 2'b10.
REQ-018 Simultaneous read and write to same register: read returns pre-write value.
REQ-019 Back-to-back: with BREADY/RREADY held high, one write and one read SHALL complete every 2 cycles each.

Reset
REQ-020 On aresetn low, asynchronously: all READY, BVALID, RVALID, unicast_valid = 0; BRESP, RRESP, RDATA = 0; unicast_addr, staging, stage_pending, mac_enable = 0; held AW/W cleared.
REQ-021 Reset mid-transaction SHALL abandon it with no register update; after release READYs assert within 1 cycle.

Structure
REQ-022 Shared package SHALL hold register offsets (UWA0/UWA1/CTRL/STATUS), RESP_OKAY/RESP_SLVERR constants, and ETH_ADDR_W = 48; the existing controller SHALL use the same offsets.
REQ-023 No sub-module; single module with separate write-path and read-path processes.

Verification
REQ-024 Write UWA0=32'hDDCCBBAA, UWA1=32'h0000_FFEE, strobe 4'hF -> unicast_addr=48'hFFEE_DDCC_BBAA, unicast_valid one pulse, BRESP 00 both.
REQ-025 AW issued 3 cycles before W, BREADY low 4 cycles -> BVALID 1 cycle after W handshake, held stable, AWREADY low until B handshake.
REQ-026 Write UWA0 only then read STATUS -> RDATA=1; read UWA0 -> old committed value; then UWA1 write -> STATUS reads 0.
REQ-027 Write 0x710 and STATUS, read 0x800 -> BRESP 2'b10 twice, RRESP 2'b10, RDATA 0, no register change.
REQ-028 WSTRB=4'b0010 data 32'h0000_5500 to UWA0 over 32'h11223344 staging -> staging 32'h11225544.
REQ-029 aresetn pulsed low while BVALID pending -> BVALID, unicast_addr, mac_enable return 0 immediately; next write completes normally.
